// File: rtl/boa_xm_sram_pkg.sv
// Shared types for the boa_xm_sram async SRAM bridge: FSM state encoding and wait-counter width.
package boa_xm_sram_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_LO,
    ST_WR_LO_REC,
    ST_WR_HI,
    ST_WR_HI_REC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/boa_mem_bus.sv
// 32-bit word memory bus; addr carries only the word-address bits [alen-1:2].
interface boa_mem_bus #(parameter int alen = 24);
  logic            re;
  logic [3:0]      we;
  logic [alen-1:2] addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_xm_sram_timer.sv
// Loadable wait-state down-counter; o_zero flags the last cycle of a timed SRAM strobe.
module boa_xm_sram_timer
  import boa_xm_sram_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/boa_xm_sram.sv
// 32-bit bus to 16-bit asynchronous SRAM bridge, two halfword accesses per word.
// Optional BOA_XM_SRAM_WRITE_SKIP_EN: skip halfwords whose byte enables are both clear.
module boa_xm_sram
  import boa_xm_sram_pkg::*;
#(
  parameter int alen        = 24,
  parameter int wait_cycles = 2
) (
  input  logic            clk,
  input  logic            rst,
  boa_mem_bus.MEM         bus,
  output logic [alen-2:0] sram_addr,
  output logic [15:0]     sram_dq_o,
  input  logic [15:0]     sram_dq_i,
  output logic            sram_dq_oe,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic            sram_ub_n,
  output logic            sram_lb_n
);

`ifdef BOA_XM_SRAM_WRITE_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(wait_cycles - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_idle_like;
  logic            w_accept;
  logic            w_zero;
  logic            w_load;

  logic [alen-1:2] r_addr;
  logic [3:0]      r_we;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [alen-1:2] w_addr_sel;
  logic [3:0]      w_we_sel;
  logic [31:0]     w_wdata_sel;

  logic [alen-2:0] r_sram_addr, w_sram_addr;
  logic [15:0]     r_dq_o, w_dq_o;
  logic            r_dq_oe, w_dq_oe;
  logic            r_ce_n, w_ce_n;
  logic            r_oe_n, w_oe_n;
  logic            r_we_n, w_we_n;
  logic            r_ub_n, w_ub_n;
  logic            r_lb_n, w_lb_n;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept    = w_idle_like && (bus.re || (bus.we != 4'b0000));

  // Pin registers for the first strobe cycle are loaded at the acceptance edge,
  // so they take the bus fields directly then and the latched copies afterwards.
  assign w_addr_sel  = w_accept ? bus.addr  : r_addr;
  assign w_we_sel    = w_accept ? bus.we    : r_we;
  assign w_wdata_sel = w_accept ? bus.wdata : r_wdata;

  assign w_load = (w_state_nxt != r_state);

  boa_xm_sram_timer u_timer (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_load),
    .i_val  (LOAD_VAL),
    .o_zero (w_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (bus.we != 4'b0000) begin
            w_state_nxt = (SKIP_EN && (bus.we[1:0] == 2'b00)) ? ST_WR_HI : ST_WR_LO;
          end else begin
            w_state_nxt = ST_RD_LO;
          end
        end
      end
      ST_RD_LO:     if (w_zero) w_state_nxt = ST_RD_HI;
      ST_RD_HI:     if (w_zero) w_state_nxt = ST_DONE;
      ST_WR_LO:     if (w_zero) w_state_nxt = ST_WR_LO_REC;
      ST_WR_LO_REC: w_state_nxt = (SKIP_EN && (r_we[3:2] == 2'b00)) ? ST_DONE : ST_WR_HI;
      ST_WR_HI:     if (w_zero) w_state_nxt = ST_WR_HI_REC;
      ST_WR_HI_REC: w_state_nxt = ST_DONE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // SRAM pin values for the state being entered; registered below.
  always_comb begin
    w_ce_n      = 1'b1;
    w_oe_n      = 1'b1;
    w_we_n      = 1'b1;
    w_ub_n      = 1'b1;
    w_lb_n      = 1'b1;
    w_dq_oe     = 1'b0;
    w_sram_addr = r_sram_addr;
    w_dq_o      = r_dq_o;
    case (w_state_nxt)
      ST_RD_LO, ST_RD_HI: begin
        w_ce_n      = 1'b0;
        w_oe_n      = 1'b0;
        w_ub_n      = 1'b0;
        w_lb_n      = 1'b0;
        w_sram_addr = {w_addr_sel, (w_state_nxt == ST_RD_HI)};
      end
      ST_WR_LO, ST_WR_LO_REC: begin
        w_ce_n      = 1'b0;
        w_we_n      = (w_state_nxt != ST_WR_LO);
        w_dq_oe     = 1'b1;
        w_ub_n      = ~w_we_sel[1];
        w_lb_n      = ~w_we_sel[0];
        w_sram_addr = {w_addr_sel, 1'b0};
        w_dq_o      = w_wdata_sel[15:0];
      end
      ST_WR_HI, ST_WR_HI_REC: begin
        w_ce_n      = 1'b0;
        w_we_n      = (w_state_nxt != ST_WR_HI);
        w_dq_oe     = 1'b1;
        w_ub_n      = ~w_we_sel[3];
        w_lb_n      = ~w_we_sel[2];
        w_sram_addr = {w_addr_sel, 1'b1};
        w_dq_o      = w_wdata_sel[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_we        <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sram_addr <= w_sram_addr;
      r_dq_o      <= w_dq_o;
      r_dq_oe     <= w_dq_oe;
      r_ce_n      <= w_ce_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_ub_n      <= w_ub_n;
      r_lb_n      <= w_lb_n;
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_we    <= bus.we;
        r_wdata <= bus.wdata;
      end
      if ((r_state == ST_RD_LO) && w_zero) r_rdata[15:0]  <= sram_dq_i;
      if ((r_state == ST_RD_HI) && w_zero) r_rdata[31:16] <= sram_dq_i;
    end
  end

  assign bus.ready  = w_idle_like;
  assign bus.rdata  = r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_boa_xm_sram.sv
// Self-checking bench for boa_xm_sram: directed vector table, corner sequences, random traffic vs word-level model.
module tb_boa_xm_sram;

  localparam int ALEN = 24;
  localparam int W    = 2;
`ifdef BOA_XM_SRAM_WRITE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic preload;
  always #5 clk = ~clk;

  boa_mem_bus #(.alen(ALEN)) bus_if();

  logic [ALEN-2:0] sram_addr;
  logic [15:0]     sram_dq_o, sram_dq_i;
  logic            sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  boa_xm_sram #(.alen(ALEN), .wait_cycles(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  function automatic logic [15:0] init_val(input int a);
    if (a == 'h200) return 16'hBEEF;
    if (a == 'h201) return 16'hDEAD;
    return 16'(a) ^ 16'hA5C3;
  endfunction

  // Asynchronous SRAM environment: 4K halfwords, byte-masked writes, protocol monitor.
  logic [15:0] sram_mem [0:4095];
  int we_lo_cnt = 0;
  int oe_lo_cnt = 0;
  int proto_err = 0;

  assign sram_dq_i = !sram_oe_n ? sram_mem[sram_addr[11:0]] : 16'h0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= init_val(i);
    end else begin
      if (!sram_ce_n && !sram_we_n) begin
        if (!sram_lb_n) sram_mem[sram_addr[11:0]][7:0]  <= sram_dq_o[7:0];
        if (!sram_ub_n) sram_mem[sram_addr[11:0]][15:8] <= sram_dq_o[15:8];
        we_lo_cnt <= we_lo_cnt + 1;
      end
      if (!sram_ce_n && !sram_oe_n) oe_lo_cnt <= oe_lo_cnt + 1;
      if ((!sram_ce_n && sram_addr[ALEN-2:12] != '0) ||
          (!sram_oe_n && sram_dq_oe) || (!sram_we_n && !sram_dq_oe) ||
          (!sram_we_n && !sram_oe_n))
        proto_err <= proto_err + 1;
    end
  end

  // Word-level reference model.
  logic [15:0] ref_mem [0:4095];

  function automatic int exp_lat(input logic [3:0] we);
    if (we == 4'b0000) return 2 * W + 1;
    if (SKIP && (we[1:0] == 2'b00 || we[3:2] == 2'b00)) return W + 2;
    return 2 * W + 3;
  endfunction

  function automatic int halfwords_written(input logic [3:0] we);
    if (we == 4'b0000) return 0;
    if (!SKIP) return 2;
    return int'(|we[1:0]) + int'(|we[3:2]);
  endfunction

  task automatic model_write(input logic [21:0] a, input logic [3:0] we, input logic [31:0] wd);
    for (int k = 0; k < 2; k++) begin
      int ha;
      ha = int'(a) * 2 + k;
      if (we[2*k])   ref_mem[ha][7:0]  = wd[16*k +: 8];
      if (we[2*k+1]) ref_mem[ha][15:8] = wd[16*k+8 +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [21:0] a);
    return {ref_mem[int'(a) * 2 + 1], ref_mem[int'(a) * 2]};
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  logic first_ce_n, first_oe_n, first_we_n;
  int   last_we_d, last_oe_d;

  task automatic drive(input logic re_i, input logic [3:0] we_i, input logic [21:0] a, input logic [31:0] wd);
    bus_if.re    = re_i;
    bus_if.we    = we_i;
    bus_if.addr  = a;
    bus_if.wdata = wd;
  endtask

  // Runs one request; latency counts cycles after the accepting edge until ready=1.
  task automatic run_txn(input logic re_i, input logic [3:0] we_i, input logic [21:0] a,
                         input logic [31:0] wd, input bit predriven, input bit hold,
                         output int lat, output logic [31:0] rd);
    int we0, oe0;
    if (!predriven) begin
      @(negedge clk);
      drive(re_i, we_i, a, wd);
    end
    we0 = we_lo_cnt;
    oe0 = oe_lo_cnt;
    @(posedge clk);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        first_ce_n = sram_ce_n;
        first_oe_n = sram_oe_n;
        first_we_n = sram_we_n;
      end
      if (bus_if.ready) break;
    end
    rd = bus_if.rdata;
    last_we_d = we_lo_cnt - we0;
    last_oe_d = oe_lo_cnt - oe0;
    if (!hold) drive(1'b0, 4'b0000, '0, '0);
  endtask

  task automatic verify(input string tag, input logic re_i, input logic [3:0] we_i,
                        input logic [21:0] a, input logic [31:0] wd, input int lat,
                        input logic [31:0] rd);
    check({tag, "_lat"}, lat, exp_lat(we_i));
    check({tag, "_we_cycles"}, last_we_d, halfwords_written(we_i) * W);
    check({tag, "_oe_cycles"}, last_oe_d, (we_i == 4'b0000) ? 2 * W : 0);
    check({tag, "_first_strobes"}, {first_ce_n, first_oe_n, first_we_n},
          (we_i == 4'b0000) ? 3'b001 : 3'b010);
    if (we_i == 4'b0000) check({tag, "_rdata"}, rd, model_read(a));
    else model_write(a, we_i, wd);
    if (!re_i && we_i == 4'b0000) check({tag, "_no_request"}, 1, 0);
  endtask

  typedef struct {
    logic        re;
    logic [3:0]  we;
    logic [21:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    int          mism;
    logic [31:0] rd;
    logic [3:0]  we_r;
    logic        re_r;
    logic [21:0] a_r;
    logic [31:0] wd_r;

    vecs[0] = '{1'b1, 4'b0000, 22'h000100, 32'h0,         5,               1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 4'b1111, 22'h000101, 32'h12345678, 7,               1'b0, 32'h0};
    vecs[2] = '{1'b1, 4'b0000, 22'h000101, 32'h0,         5,               1'b1, 32'h12345678};
    vecs[3] = '{1'b0, 4'b0100, 22'h000101, 32'hAABBCCDD, SKIP ? 4 : 7,    1'b0, 32'h0};
    vecs[4] = '{1'b1, 4'b0000, 22'h000101, 32'h0,         5,               1'b1, 32'h12BB5678};
    vecs[5] = '{1'b1, 4'b0011, 22'h000102, 32'h00009999, SKIP ? 4 : 7,    1'b0, 32'h0};
    vecs[6] = '{1'b1, 4'b0000, 22'h000102, 32'h0,         5,               1'b1, 32'hA7C69999};
    vecs[7] = '{1'b0, 4'b1000, 22'h0007FF, 32'hFF000000, SKIP ? 4 : 7,    1'b0, 32'h0};
    vecs[8] = '{1'b1, 4'b0000, 22'h0007FF, 32'h0,         5,               1'b1, 32'hFF3CAA3D};

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
    drive(1'b0, 4'b0000, '0, '0);
    rst = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", bus_if.ready, 1'b1);
    check("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    check("reset_dq_oe", sram_dq_oe, 1'b0);
    check("reset_sram_addr", sram_addr, '0);
    check("reset_dq_o", sram_dq_o, '0);
    check("reset_rdata", bus_if.rdata, '0);
    rst = 1'b0;
    preload = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, 1'b0, lat, rd);
      check($sformatf("vec%0d_lat_const", i), lat, vecs[i].lat);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata_const", i), rd, vecs[i].rd);
      verify($sformatf("vec%0d", i), vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
    end

    // Back-to-back: write presented at the read's completion edge.
    run_txn(1'b1, 4'b0000, 22'h000100, '0, 1'b0, 1'b1, lat, rd);
    verify("b2b_read", 1'b1, 4'b0000, 22'h000100, '0, lat, rd);
    drive(1'b0, 4'b1111, 22'h0000AB, 32'hCAFEF00D);
    run_txn(1'b0, 4'b1111, 22'h0000AB, 32'hCAFEF00D, 1'b1, 1'b0, lat, rd);
    verify("b2b_write", 1'b0, 4'b1111, 22'h0000AB, 32'hCAFEF00D, lat, rd);

    // Reset during WR_LO: low half rewrites its current value, high half must stay untouched.
    a_r  = 22'h000150;
    wd_r = {~ref_mem['h2A1], ref_mem['h2A0]};
    @(negedge clk);
    drive(1'b0, 4'b1111, a_r, wd_r);
    we_r = 4'b1111;
    lat  = we_lo_cnt;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_wr_lo", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b001);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_strobes", {sram_we_n, sram_ce_n, sram_dq_oe, bus_if.ready}, 4'b1101);
    rst = 1'b0;
    drive(1'b0, 4'b0000, '0, '0);
    repeat (6) @(negedge clk);
    check("abort_we_cycles", we_lo_cnt - lat, 1);
    check("abort_idle_ready", bus_if.ready, 1'b1);
    if (we_r != 4'b1111) check("abort_setup", 0, 1);

    for (int n = 0; n < 80; n++) begin
      re_r = 1'($urandom_range(0, 1));
      we_r = 4'($urandom_range(0, 15));
      if (we_r == 4'b0000) re_r = 1'b1;
      a_r  = 22'($urandom_range(0, 'h7FF));
      wd_r = $urandom;
      run_txn(re_r, we_r, a_r, wd_r, 1'b0, 1'b0, lat, rd);
      verify($sformatf("rnd%0d", n), re_r, we_r, a_r, wd_r, lat, rd);
    end

    @(negedge clk);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
    check("final_memory_mismatches", mism, 0);
    check("protocol_errors", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boa_xm_sram.md
BOA_XM_SRAM -- requirements
Module: boa_xm_sram

Interface
REQ-001 Parameter alen, default 24: address bits; the bus addresses 32-bit words via addr[alen-1:2].
REQ-002 Parameter wait_cycles, default 2: clk cycles each SRAM strobe is held; legal range 1..15.
REQ-003 Port clk, input, 1: the only clock; all logic on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port bus, boa_mem_bus.MEM: responder side (re, we[3:0], addr, wdata, rdata, ready).
REQ-006 Port sram_addr, output, alen-1: halfword address to the async SRAM.
REQ-007 Port sram_dq_o, output, 16: write data. Port sram_dq_i, input, 16: read data. Port sram_dq_oe, output, 1: drive enable.
REQ-008 Ports sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, output, 1 each: active-low SRAM strobes.

Function
REQ-009 Acceptance: in IDLE, at any edge where re=1 or we!=0 the request is accepted (cycle N); addr, wdata and we are latched.
REQ-010 Both re=1 and we!=0: the write is performed; rdata is unspecified.
REQ-011 ready=1 in IDLE; ready=0 from N+1 until the completion cycle; ready=1 in the completion cycle.
REQ-012 The requester holds its signals while ready=0; the block ignores bus inputs outside IDLE and the completion cycle.
REQ-013 Back-to-back: a request present at the completion edge is accepted there with no idle cycle.
REQ-014 Mapping: low halfword (wdata[15:0], we[1:0]) at sram_addr={addr,1'b0}; high halfword at {addr,1'b1}; ub_n=!we[2k+1], lb_n=!we[2k].
REQ-015 States: IDLE, RD_LO, RD_HI, WR_LO, WR_LO_REC, WR_HI, WR_HI_REC, DONE.
REQ-016 Read: RD_LO for W=wait_cycles cycles (ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0), sample sram_dq_i into rdata[15:0] at its last edge; RD_HI likewise into rdata[31:16]; then DONE.
REQ-017 Read completion: ready=1 at cycle N+2W+1; rdata registered, valid only in that cycle.
REQ-018 Write halfword: WR_x for W cycles (ce_n=0, we_n=0, dq_oe=1, data/addr/byte strobes stable), then WR_x_REC for 1 cycle (we_n=1, ce_n=0, data still driven).
REQ-019 Write completion: ready=1 at N+2W+3 when both halfwords are written.
REQ-020 Wait counter counts W-1 down to 0; 4 bits wide; wraps only via reload on state entry.
REQ-021 sram_addr, sram_dq_o and all strobes are registered outputs; no combinational path from bus inputs to SRAM pins.
REQ-022 Outside active states: ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0.

Reset
REQ-023 At a rst edge: state IDLE, ready=1, ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0, sram_addr=0, sram_dq_o=0, rdata=0, counter=0.
REQ-024 rst mid-operation aborts the transfer; strobes deassert in the cycle after the rst edge; no completion is signalled for the aborted request.

Configuration
REQ-025 Macro BOA_XM_SRAM_WRITE_SKIP_EN defined: a halfword whose two write enables are both 0 is skipped (WR_x and WR_x_REC bypassed); single-halfword writes complete at N+W+2.
REQ-026 Macro absent: both halfwords are always written; disabled bytes are masked only by ub_n/lb_n=1.

Structure
REQ-027 Package boa_xm_sram_pkg holds the state enum typedef and the counter width constant (4).
REQ-028 Sub-module boa_xm_sram_timer: loadable down-counter with a zero flag; all other logic lives in boa_xm_sram.

Verification (alen=24, wait_cycles=2)
REQ-029 Read addr=0x000100, SRAM returns 0xBEEF at 0x000200 and 0xDEAD at 0x000201 -> ready=1 at N+5, rdata=0xDEADBEEF.
REQ-030 Write we=4'b1111, wdata=0x12345678 -> 0x5678 at even, 0x1234 at odd, we_n low 2 cycles each, ready at N+7.
REQ-031 WRITE_SKIP_EN defined, we=4'b0100 -> only high halfword written with ub_n=1, lb_n=0, ready at N+4; macro absent -> both halfwords written, low with ub_n=lb_n=1, ready at N+7.
REQ-032 Read, then write held at the completion edge -> write accepted there, RD_HI followed directly by WR_LO after DONE, no IDLE cycle.
REQ-033 rst asserted during WR_LO -> next cycle we_n=1, ce_n=1, dq_oe=0, ready=1; no further SRAM write occurs.
REQ-034 re=1 and we=4'b0011 together -> write sequence only, oe_n stays 1 throughout.
